// File: rtl/reset_request_gen_pkg.sv
// Shared definitions for the reset request generator: FSM state encoding,
// the minimum legal hold length, and helpers for sizing and checking the
// counters. No ports.
package reset_request_gen_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        HOLD     = 2'd1,
        WAIT_ACK = 2'd2
    } state_e;

    localparam int unsigned MIN_HOLD_CYCLES = 10;

    // A counter that must reach n-1 needs at least one bit, even when n <= 2.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Elaboration-time legality check for the hold length.
    function automatic bit hold_cycles_ok(input int unsigned n);
        return n >= MIN_HOLD_CYCLES;
    endfunction

endpackage

// File: rtl/reset_request_gen_cycle_counter.sv
// cycle_counter: up-counter with synchronous clear and a terminal-count
// compare. It saturates at TERMINAL, so it can never wrap.
// Ports:
//   clk            clock, posedge
//   rst_n          synchronous active-low reset
//   clear          forces the count to 0 (priority over enable)
//   enable         advance the count by one
//   at_terminal_c  combinational: count == TERMINAL
module cycle_counter #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned TERMINAL = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic at_terminal_c
);

    logic [WIDTH-1:0] count;

    assign at_terminal_c = (count == WIDTH'(TERMINAL));

    // Count register; holds at the terminal value instead of wrapping.
    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            count <= '0;
        end else if (enable && !at_terminal_c) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/reset_request_gen.sv
// reset_request_gen: issues an active-low reset request to a consumer, either
// on an explicit Req or when an enabled watchdog is not kicked in time, holds
// it low for HOLD_CYCLES, then waits up to ACK_TIMEOUT cycles for the
// consumer's acknowledge.
// Ports:
//   CLK          clock, posedge
//   Reset_L      synchronous active-low reset
//   Req          explicit reset request
//   Kick         watchdog service strobe
//   WdogEn       watchdog enable (count held at 0 when low)
//   Reset_Ack_L  active-low acknowledge from the reset consumer
//   ErrClr       clears Timeout_Err
//   Req_Reset_L  registered active-low reset request
//   Busy         registered, high while in HOLD or WAIT_ACK
//   Wdog_Fired   registered one-cycle pulse when the watchdog starts a sequence
//   Timeout_Err  registered sticky flag: acknowledge never arrived
module reset_request_gen
    import reset_request_gen_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES = 12,
    parameter int unsigned WDOG_CYCLES = 1000,
    parameter int unsigned ACK_TIMEOUT = 64
) (
    input  logic CLK,
    input  logic Reset_L,
    input  logic Req,
    input  logic Kick,
    input  logic WdogEn,
    input  logic Reset_Ack_L,
    input  logic ErrClr,
    output logic Req_Reset_L,
    output logic Busy,
    output logic Wdog_Fired,
    output logic Timeout_Err
);

    localparam int unsigned HOLD_W = cnt_width(HOLD_CYCLES);
    localparam int unsigned WDOG_W = cnt_width(WDOG_CYCLES);
    localparam int unsigned ACK_W  = cnt_width(ACK_TIMEOUT);

    if (!hold_cycles_ok(HOLD_CYCLES)) begin : g_hold_check
        $error("reset_request_gen: HOLD_CYCLES below MIN_HOLD_CYCLES");
    end

    state_e state;

    logic hold_tc_c;
    logic wdog_tc_c;
    logic ack_tc_c;
    logic wdog_run_c;
    logic wdog_expire_c;
    logic start_c;
    logic ack_seen_c;
    logic ack_timeout_c;

    // Sequence start / end decisions; Kick beats a coincident expiry.
    always_comb begin
        wdog_run_c    = (state == IDLE) && WdogEn;
        wdog_expire_c = wdog_run_c && !Kick && wdog_tc_c;
        start_c       = (state == IDLE) && (Req || wdog_expire_c);
        ack_seen_c    = (state == WAIT_ACK) && !Reset_Ack_L;
        ack_timeout_c = (state == WAIT_ACK) && Reset_Ack_L && ack_tc_c;
    end

    // Low-time of the request: terminal at HOLD_CYCLES-1 gives exactly
    // HOLD_CYCLES low cycles counting the entry edge.
    cycle_counter #(
        .WIDTH    (HOLD_W),
        .TERMINAL (HOLD_CYCLES - 1)
    ) u_hold_cnt (
        .clk           (CLK),
        .rst_n         (Reset_L),
        .clear         (state != HOLD),
        .enable        (state == HOLD),
        .at_terminal_c (hold_tc_c)
    );

    // Watchdog idle count; cleared by Kick, by disable, and on any start.
    cycle_counter #(
        .WIDTH    (WDOG_W),
        .TERMINAL (WDOG_CYCLES - 1)
    ) u_wdog_cnt (
        .clk           (CLK),
        .rst_n         (Reset_L),
        .clear         (!wdog_run_c || Kick || start_c),
        .enable        (wdog_run_c),
        .at_terminal_c (wdog_tc_c)
    );

    // Cycles spent waiting for the acknowledge.
    cycle_counter #(
        .WIDTH    (ACK_W),
        .TERMINAL (ACK_TIMEOUT - 1)
    ) u_ack_cnt (
        .clk           (CLK),
        .rst_n         (Reset_L),
        .clear         (state != WAIT_ACK),
        .enable        (state == WAIT_ACK),
        .at_terminal_c (ack_tc_c)
    );

    // State register with registered outputs.
    always_ff @(posedge CLK) begin
        if (!Reset_L) begin
            state       <= IDLE;
            Req_Reset_L <= 1'b1;
            Busy        <= 1'b0;
            Wdog_Fired  <= 1'b0;
            Timeout_Err <= 1'b0;
        end else begin
            Wdog_Fired <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_c) begin
                        state       <= HOLD;
                        Req_Reset_L <= 1'b0;
                        Busy        <= 1'b1;
                        Wdog_Fired  <= wdog_expire_c;
                    end
                end
                HOLD: begin
                    if (hold_tc_c) begin
                        state       <= WAIT_ACK;
                        Req_Reset_L <= 1'b1;
                    end
                end
                WAIT_ACK: begin
                    if (ack_seen_c || ack_timeout_c) begin
                        state <= IDLE;
                        Busy  <= 1'b0;
                    end
                end
                default: begin
                    state       <= IDLE;
                    Req_Reset_L <= 1'b1;
                    Busy        <= 1'b0;
                end
            endcase

            // Set has priority over a coincident clear.
            if (ack_timeout_c) begin
                Timeout_Err <= 1'b1;
            end else if (ErrClr) begin
                Timeout_Err <= 1'b0;
            end
        end
    end

endmodule
